ysyx_23060208_icache: RTL and testbench
=======================================

Name: ysyx_23060208_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU fetch port and the arbiter's isram read channel.
- Upstream side is an AXI-lite read slave facing the IFU; downstream side is an AXI-lite read master facing the arbiter.
- Misses refill a whole line as sequential single-beat reads. Hits are answered without touching the arbiter.
- Provides whole-cache invalidation for fence.i and hit/miss performance counters.

Parameters:
- DATA_WIDTH, 32, word and address width.
- INDEX_BITS, 4, log2 of line count (16 lines).
- OFFSET_BITS, 4, log2 of line bytes (16 B = 4 words). Tag width = DATA_WIDTH-INDEX_BITS-OFFSET_BITS.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_araddr  in  32  fetch address; bits [1:0] ignored.
- ifu_arvalid  in  1  fetch request valid.
- ifu_arready  out  1  cache accepts a request.
- ifu_rdata  out  32  instruction word.
- ifu_rresp  out  2  00 OKAY, 10 SLVERR.
- ifu_rvalid  out  1  response valid.
- ifu_rready  in  1  IFU accepts the response.
- mem_araddr  out  32  refill word address to the arbiter.
- mem_arvalid  out  1  refill request valid.
- mem_arready  in  1  arbiter accepts the request.
- mem_rdata  in  32  refill data.
- mem_rresp  in  2  refill response code.
- mem_rvalid  in  1  refill data valid.
- mem_rready  out  1  cache accepts refill data.
- fence_i  in  1  invalidate request, single-cycle pulse.
- hit_cnt  out  32  count of hits, wraps.
- miss_cnt  out  32  count of misses, wraps.

Behaviour:
- States: IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP. Encoding is 3 bits.
- Reset (rst=1): state=IDLE and all valid bits cleared. Outputs while reset is asserted: ifu_arready=0, ifu_rvalid=0, ifu_rdata=0, ifu_rresp=0, mem_arvalid=0, mem_rready=0, mem_araddr=0, hit_cnt=0, miss_cnt=0.
- Reset mid-refill: the refill is abandoned, and the partially written line stays invalid.
- IDLE:
  - ifu_arready=1 unless an invalidation is pending.
  - On ifu_arvalid&&ifu_arready: latch the address into req_addr and go to LOOKUP.
- LOOKUP (one cycle): read the valid bit and tag at req_addr[index].
  - Hit: latch the word at req_addr[OFFSET_BITS-1:2] into ifu_rdata, set rresp=00, hit_cnt+1, go to RESP.
  - Miss: miss_cnt+1, word_cnt=0, err=0, go to REFILL_AR.
- Hit latency: the handshake in cycle T gives ifu_rvalid=1 in cycle T+2.
- REFILL_AR:
  - mem_arvalid=1 with mem_araddr={req tag, index, word_cnt, 2'b00}.
  - mem_araddr is held stable until mem_arready. On the handshake go to REFILL_R.
- REFILL_R:
  - mem_rready=1. On mem_rvalid, write mem_rdata into data[index][word_cnt].
  - If mem_rresp!=00, set err.
  - If word_cnt==requested word, capture that data into the response register.
  - If word_cnt < 3: word_cnt+1, go to REFILL_AR. Otherwise go to RESP.
  - At the end of the line: if err=0, set the tag and valid=1. If err=1, leave valid=0 and set ifu_rresp=10.
- Refill order is always word 0 to 3. There is no critical-word-first. At most one outstanding downstream request.
- RESP:
  - ifu_rvalid=1, with rdata and rresp held stable until ifu_rready.
  - The handshake returns the block to IDLE.
  - ifu_rvalid may stay high for any number of cycles without data change.
- fence_i:
  - In IDLE with no simultaneous accept: clear all valid bits at the next edge.
  - In any other state, or coincident with a request: set inval_pend.
  - inval_pend deasserts ifu_arready in IDLE. The invalidation applies on the first IDLE cycle, then inval_pend clears.
  - A refill in flight when fence_i arrives still completes and responds, but the line is then cleared by the pending invalidation.
- Counters: plain 32-bit modulo-2^32 increments. 0xFFFFFFFF wraps to 0.
- Arrays: the valid array is flops. Tag and data arrays have a combinational read and one synchronous write port.

Decomposition:
- Shared header/package holds:
  - state encodings (S_IDLE=0 … S_RESP=4);
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - INDEX/OFFSET/TAG field widths and the word-select macro.
- One sub-module: ysyx_23060208_icache_array. It holds the tag, valid and data storage, one write port (word-granular data write plus tag/valid write), a combinational read by index, and a flash-clear of valid.
- The FSM, counters and handshakes stay in the top block.

Test Plan:
- Cold miss: after reset, fetch 0x80000004 → 4 mem reads at 0x80000000/04/08/0C. ifu_rdata = word at 0x80000004, rresp=00, miss_cnt=1.
- Hit: then fetch 0x8000000C → no mem_arvalid, rvalid exactly 2 cycles after the handshake, hit_cnt=1.
- Conflict eviction: fetch 0x80000100 (same index, new tag) → miss and refill. A re-fetch of 0x80000004 misses again, miss_cnt=3.
- Refill error: mem_rresp=10 on beat 2 → ifu_rresp=10 and the line stays invalid. A re-fetch of the same address misses again.
- fence_i during REFILL_R: the response still returns correct data. arready stays 0 for one IDLE cycle, then the same address misses.
- Backpressure and reset: ifu_rready=0 for 5 cycles holds rvalid and rdata stable. rst asserted during REFILL_R forces all outputs to 0 immediately, and the next fetch misses.

Source files
------------

// File: rtl/ysyx_23060208_icache_pkg.sv
// ysyx_23060208_icache_pkg: shared state encoding, response codes and field widths for the icache
package ysyx_23060208_icache_pkg;
  localparam int DATA_W = 32;
  localparam int INDEX_W = 4;
  localparam int OFFSET_W = 4;
  localparam int TAG_W = DATA_W - INDEX_W - OFFSET_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_REFILL_AR = 3'd2,
    S_REFILL_R  = 3'd3,
    S_RESP      = 3'd4
  } state_e;
  function automatic logic [WORD_W-1:0] word_sel(input logic [DATA_W-1:0] addr);
    return addr[OFFSET_W-1:2];
  endfunction
endpackage

// File: rtl/ysyx_23060208_icache_array.sv
// ysyx_23060208_icache_array: tag/valid/data storage with combinational read, one write port and valid flash-clear
module ysyx_23060208_icache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS = 24,
  parameter int WORD_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [WORD_BITS-1:0]  rword_i,
  output logic                  vld_o,
  output logic [TAG_BITS-1:0]   tag_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  we_i,
  input  logic [WORD_BITS-1:0]  wword_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  tag_we_i,
  input  logic [TAG_BITS-1:0]   wtag_i,
  input  logic                  wvalid_i,
  input  logic                  clr_i
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES << WORD_BITS];
  assign vld_o  = valid_q[idx_i];
  assign tag_o  = tag_q[idx_i];
  assign data_o = data_q[{idx_i, rword_i}];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else if (clr_i) valid_q <= '0;
    else if (tag_we_i) valid_q[idx_i] <= wvalid_i;
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= wtag_i;
    if (we_i) data_q[{idx_i, wword_i}] <= wdata_i;
  end
endmodule

// File: rtl/ysyx_23060208_icache.sv
// ysyx_23060208_icache: direct-mapped read-only instruction cache between IFU and arbiter
module ysyx_23060208_icache
  import ysyx_23060208_icache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int INDEX_BITS = INDEX_W,
  parameter int OFFSET_BITS = OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  output logic [DATA_WIDTH-1:0] mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic                  fence_i,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int TB = DATA_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WB = OFFSET_BITS - 2;
  state_e                  state_q;
  logic [DATA_WIDTH-1:2]   req_q;
  logic [WB-1:0]           cnt_q, cnt_nx, req_word;
  logic                    err_q, inval_q, err_n, accept, beat, last, hit, clr;
  logic [TB-1:0]           req_tag, line_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic                    line_vld;
  logic [DATA_WIDTH-1:0]   line_word;
  logic                    unused_addr;
  assign unused_addr = ^ifu_araddr[1:0];
  assign req_tag  = req_q[DATA_WIDTH-1 -: TB];
  assign req_idx  = req_q[OFFSET_BITS +: INDEX_BITS];
  assign req_word = req_q[2 +: WB];
  assign cnt_nx   = cnt_q + WB'(1);
  assign accept   = state_q == S_IDLE && ifu_arready && ifu_arvalid;
  assign beat     = state_q == S_REFILL_R && mem_rvalid;
  assign last     = cnt_q == '1;
  assign err_n    = err_q | (mem_rresp != RESP_OKAY);
  assign hit      = line_vld && line_tag == req_tag;
  // a fence that cannot apply right now is parked until the block is idle again
  assign clr      = state_q == S_IDLE && (inval_q || (fence_i && !accept));

  ysyx_23060208_icache_array #(
    .DATA_WIDTH(DATA_WIDTH), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TB), .WORD_BITS(WB)
  ) u_array (
    .clk(clk), .rst(rst), .idx_i(req_idx), .rword_i(req_word),
    .vld_o(line_vld), .tag_o(line_tag), .data_o(line_word),
    .we_i(beat), .wword_i(cnt_q), .wdata_i(mem_rdata),
    .tag_we_i(beat && last), .wtag_i(req_tag), .wvalid_i(!err_n), .clr_i(clr)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      inval_q     <= 1'b0;
      ifu_arready <= 1'b0;
      ifu_rvalid  <= 1'b0;
      ifu_rdata   <= '0;
      ifu_rresp   <= RESP_OKAY;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
      mem_rready  <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (accept) begin
            req_q       <= ifu_araddr[DATA_WIDTH-1:2];
            ifu_arready <= 1'b0;
            state_q     <= S_LOOKUP;
          end else begin
            ifu_arready <= 1'b1;
            inval_q     <= 1'b0;
          end
        S_LOOKUP:
          if (hit) begin
            ifu_rdata  <= line_word;
            ifu_rresp  <= RESP_OKAY;
            ifu_rvalid <= 1'b1;
            hit_cnt    <= hit_cnt + 32'd1;
            state_q    <= S_RESP;
          end else begin
            miss_cnt    <= miss_cnt + 32'd1;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_arvalid <= 1'b1;
            mem_araddr  <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
            state_q     <= S_REFILL_AR;
          end
        S_REFILL_AR:
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            state_q     <= S_REFILL_R;
          end
        S_REFILL_R:
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            err_q      <= err_n;
            if (cnt_q == req_word) ifu_rdata <= mem_rdata;
            if (last) begin
              ifu_rresp  <= err_n ? RESP_SLVERR : RESP_OKAY;
              ifu_rvalid <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              cnt_q       <= cnt_nx;
              mem_arvalid <= 1'b1;
              mem_araddr  <= {req_tag, req_idx, cnt_nx, 2'b00};
              state_q     <= S_REFILL_AR;
            end
          end
        S_RESP:
          if (ifu_rready) begin
            ifu_rvalid  <= 1'b0;
            ifu_arready <= !(inval_q || fence_i);
            state_q     <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
      if (fence_i && (state_q != S_IDLE || accept)) inval_q <= 1'b1;
    end
endmodule

// File: tb/tb_ysyx_23060208_icache.sv
// tb_ysyx_23060208_icache: directed table, corner sequences and random fetches against a line-level cache model
module tb_ysyx_23060208_icache;
  logic        clk = 1'b0, rst;
  logic [31:0] ifu_araddr, ifu_rdata, mem_araddr, mem_rdata, hit_cnt, miss_cnt;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [1:0]  ifu_rresp, mem_rresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready, fence_i;

  ysyx_23060208_icache dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .fence_i(fence_i), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int          npass = 0, ntot = 0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] mem_log[$];
  bit          mv[16];
  logic [23:0] mt[16];
  logic [31:0] exp_hit, exp_miss;

  typedef struct { logic [31:0] addr; bit hit; int hold; } vec_t;
  vec_t tbl[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    exp_hit = 0;
    exp_miss = 0;
  endtask

  // line-level view: a miss brings in the whole 16-byte line, any bad beat poisons it
  task automatic model_access(input logic [31:0] a, output bit hit, output logic [1:0] resp);
    int idx;
    bit bad;
    idx = int'(a[7:4]);
    hit = mv[idx] && mt[idx] == a[31:8];
    bad = 1'b0;
    if (hit) begin exp_hit++; resp = 2'b00; end
    else begin
      exp_miss++;
      for (int w = 0; w < 4; w++) if ({a[31:4], 4'h0} + 32'(4 * w) == err_addr) bad = 1'b1;
      resp = bad ? 2'b10 : 2'b00;
      mv[idx] = !bad;
      mt[idx] = a[31:8];
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_arready"}, 32'(ifu_arready), 0);
    chk({p, "_rvalid"}, 32'(ifu_rvalid), 0);
    chk({p, "_rdata"}, ifu_rdata, 0);
    chk({p, "_rresp"}, 32'(ifu_rresp), 0);
    chk({p, "_mem_arvalid"}, 32'(mem_arvalid), 0);
    chk({p, "_mem_rready"}, 32'(mem_rready), 0);
    chk({p, "_mem_araddr"}, mem_araddr, 0);
    chk({p, "_hit_cnt"}, hit_cnt, 0);
    chk({p, "_miss_cnt"}, miss_cnt, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input int hold, input logic [31:0] ed,
                       output logic [31:0] d, output logic [1:0] r, output int lat, output bit ok);
    int n;
    ok = 1'b0;
    lat = 0;
    d = '0;
    r = '0;
    @(negedge clk);
    ifu_araddr = a;
    ifu_arvalid = 1'b1;
    n = 0;
    while (!ifu_arready && n < 100) begin @(negedge clk); n++; end
    if (!ifu_arready) begin ifu_arvalid = 1'b0; return; end
    @(negedge clk);
    ifu_arvalid = 1'b0;
    lat = 1;
    while (!ifu_rvalid && lat < 500) begin @(negedge clk); lat++; end
    if (!ifu_rvalid) return;
    d = ifu_rdata;
    r = ifu_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(ifu_rvalid), 1);
      chk("hold_rdata", ifu_rdata, ed);
    end
    ifu_rready = 1'b1;
    @(negedge clk);
    ifu_rready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic access(input logic [31:0] a, input int hold, output bit obs_hit);
    bit mh, ok;
    logic [1:0] er, r;
    logic [31:0] ed, d;
    int lat;
    model_access(a, mh, er);
    ed = mem_word({a[31:2], 2'b00});
    mem_log.delete();
    fetch(a, hold, ed, d, r, lat, ok);
    obs_hit = 1'b0;
    chk("fetch_done", 32'(ok), 1);
    if (!ok) return;
    obs_hit = mem_log.size() == 0;
    chk("rresp", 32'(r), 32'(er));
    if (er == 2'b00) chk("rdata", d, ed);
    chk("nreads", 32'(mem_log.size()), mh ? 0 : 4);
    if (mh) chk("hit_lat", 32'(lat), 2);
    else for (int i = 0; i < mem_log.size() && i < 4; i++)
      chk("refill_addr", mem_log[i], {a[31:4], 4'h0} + 32'(4 * i));
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
  endtask

  // arbiter stand-in: random accept and data delays, one outstanding read
  initial begin
    int ph, dly;
    logic [31:0] cur;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    ph = 0; dly = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; ph = 0;
      end else if (ph == 0) begin
        if (mem_arready) begin mem_arready = 1'b0; ph = 1; dly = int'($urandom % 3); end
        else if (mem_arvalid && $urandom % 2 == 0) begin
          mem_arready = 1'b1; cur = mem_araddr; mem_log.push_back(cur);
        end
      end else begin
        if (mem_rvalid) begin mem_rvalid = 1'b0; ph = 0; end
        else if (dly > 0) dly--;
        else if (mem_rready) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_word(cur);
          mem_rresp = (cur == err_addr) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit oh;
    int n;
    logic [31:0] a;
    tbl = '{'{32'h80000004, 1'b0, 0}, '{32'h8000000C, 1'b1, 0}, '{32'h80000100, 1'b0, 0},
            '{32'h80000004, 1'b0, 0}, '{32'h80000008, 1'b1, 5}};
    rst = 1'b1; ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0; fence_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      access(tbl[i].addr, tbl[i].hold, oh);
      chk("tbl_hit", 32'(oh), 32'(tbl[i].hit));
    end
    chk("eviction_miss_cnt", miss_cnt, 3);
    chk("eviction_hit_cnt", hit_cnt, 2);

    err_addr = 32'h80000208;
    access(32'h80000200, 0, oh);
    access(32'h80000200, 0, oh);
    chk("err_refetch_misses", 32'(oh), 0);
    err_addr = 32'h1;
    access(32'h80000200, 0, oh);
    access(32'h80000204, 0, oh);
    chk("err_recovered_hit", 32'(oh), 1);

    fork
      access(32'h80000304, 0, oh);
      begin
        n = 0;
        while (!mem_rready && n < 200) begin @(negedge clk); n++; end
        chk("fence_window", 32'(mem_rready), 1);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
      end
    join
    model_clear();
    chk("arready_fence_pend", 32'(ifu_arready), 0);
    @(negedge clk);
    chk("arready_fence_done", 32'(ifu_arready), 1);
    access(32'h80000304, 0, oh);
    chk("fence_refetch_misses", 32'(oh), 0);

    @(negedge clk);
    ifu_araddr = 32'h80000008;
    ifu_arvalid = 1'b1;
    n = 0;
    while (!ifu_arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    ifu_arvalid = 1'b0;
    n = 0;
    while (!mem_rready && n < 200) begin @(negedge clk); n++; end
    chk("rst_window", 32'(mem_rready), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrefill_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(32'h80000008, 0, oh);
    chk("rst_refetch_miss_cnt", miss_cnt, 1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom % 8 == 0) begin
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
        model_clear();
      end
      a = 32'h80000000 | (32'($urandom % 2) << 8) | (32'($urandom % 3) << 4) | (32'($urandom % 4) << 2);
      access(a, int'($urandom % 3), oh);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
